// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider: one trial subtraction per cycle, start/done handshake.
// Optional two's-complement operands when SEQ_DIV_SIGNED_EN is defined.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   state_dbg
);

    // Handshake: start is taken on a rising edge only while busy=0 (IDLE or the
    // DONE cycle); done pulses for one cycle and results hold until the next accept.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [N-1:0]    r, q, d;
    logic [CW-1:0]   cnt;
    logic            load, load_zero, step, finish;
    logic [N-1:0]    r_shift, r_next, q_next;
    logic [N:0]      diff;
    logic [N-1:0]    a_mag, b_mag, q_res, r_res;
    logic            unused_r_msb;

    // r stays below 2^(N-1) until the last step, so its MSB never needs shifting out.
    assign r_shift      = {r[N-2:0], q[N-1]};
    assign unused_r_msb = r[N-1];
    assign diff         = {1'b0, r_shift} - {1'b0, d};
    assign r_next       = diff[N] ? r_shift : diff[N-1:0];
    assign q_next       = {q[N-2:0], ~diff[N]};

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign a_mag = dividend[N-1] ? -dividend : dividend;
    assign b_mag = divisor[N-1]  ? -divisor  : divisor;
    assign q_res = neg_q ? -q_next : q_next;
    assign r_res = neg_r ? -r_next : r_next;
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
    assign q_res = q_next;
    assign r_res = r_next;
`endif

    assign busy      = (state == CALC);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        load_zero  = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_next = DONE;
                        load_zero  = 1'b1;
                    end else begin
                        state_next = CALC;
                        load       = 1'b1;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            state <= state_next;
            if (load) begin
                r           <= '0;
                q           <= a_mag;
                d           <= b_mag;
                cnt         <= CW'(N);
                div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                neg_q       <= dividend[N-1] ^ divisor[N-1];
                neg_r       <= dividend[N-1];
`endif
            end
            if (load_zero) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
            if (step) begin
                r   <= r_next;
                q   <= q_next;
                cnt <= cnt - CW'(1);
            end
            // Signs (if any) are folded in as the final step lands in DONE.
            if (finish) begin
                quotient  <= q_res;
                remainder <= r_res;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: expected results queued at start,
// compared when done pulses. Define SEQ_DIV_SIGNED_EN to match a signed DUT build.
module tb_seq_restoring_divider;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend, divisor;
    logic         busy, done, div_by_zero;
    logic [N-1:0] quotient, remainder;
    logic [1:0]   state_dbg;

    logic [2*N:0] exp_q[$];
    logic [2*N:0] mon_e;
    int           checks = 0;
    int           failures = 0;

    seq_restoring_divider #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: {quotient, remainder, div_by_zero}
    function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] qq, rr;
        logic         z;
`ifdef SEQ_DIV_SIGNED_EN
        int ai, bi;
`endif
        if (b == '0) begin
            qq = '1;
            rr = a;
            z  = 1'b1;
        end else begin
`ifdef SEQ_DIV_SIGNED_EN
            ai = $signed(a);
            bi = $signed(b);
            qq = N'(ai / bi);
            rr = N'(ai % bi);
`else
            qq = a / b;
            rr = a % b;
`endif
            z = 1'b0;
        end
        return {qq, rr, z};
    endfunction

    // Scoreboard: every done pops one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("quotient", 32'(quotient), 32'(mon_e[2*N:N+1]));
                check_eq("remainder", 32'(remainder), 32'(mon_e[N:1]));
                check_eq("div_by_zero", 32'(div_by_zero), 32'(mon_e[0]));
            end
        end
    end

    // Called right after a negedge; returns at the negedge after done.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N:0] e;
        int lat;
        e = model(a, b);
        exp_q.push_back(e);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            check_eq("busy_during_op", 32'(busy), (b != '0) ? 1 : 0);
            @(negedge clk);
            lat++;
        end
        check_eq("latency", lat, (b != '0) ? N + 1 : 1);
        check_eq("busy_at_done", 32'(busy), 0);
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done), 0);
        check_eq("quotient_held", 32'(quotient), 32'(e[2*N:N+1]));
        check_eq("remainder_held", 32'(remainder), 32'(e[N:1]));
    endtask

    task automatic wait_done(input string tag);
        int lat;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check_eq(tag, lat, N + 1);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_quotient", 32'(quotient), 0);
        check_eq("rst_remainder", 32'(remainder), 0);
        check_eq("rst_dbz", 32'(div_by_zero), 0);
        check_eq("rst_state", 32'(state_dbg), 0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef SEQ_DIV_SIGNED_EN
        run_op(4'b1001, 4'b0010);
        run_op(4'b1000, 4'b1111);
        run_op(4'b0111, 4'b1110);
        run_op(4'b1001, 4'b0000);
`endif
        run_op(4'd13, 4'd3);
        run_op(4'd7, 4'd0);
        run_op(4'd15, 4'd1);
        run_op(4'd2, 4'd9);
        run_op(4'd15, 4'd15);
        run_op(4'd0, 4'd5);

        // start while busy must be ignored
        exp_q.push_back(model(4'd9, 4'd4));
        dividend = 4'd9;
        divisor  = 4'd4;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd15;
        divisor  = 4'd15;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        begin
            int lat;
            lat = 3;
            while (!done && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            check_eq("ignored_start_latency", lat, N + 1);
        end
        repeat (N + 3) @(negedge clk);
        check_eq("ignored_start_drained", exp_q.size(), 0);

        // back-to-back: start held through done
        exp_q.push_back(model(4'd13, 4'd3));
        exp_q.push_back(model(4'd14, 4'd5));
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd14;
        divisor  = 4'd5;
        wait_done("b2b_first_latency");
        @(negedge clk);
        start = 1'b0;
        check_eq("b2b_busy_again", 32'(busy), 1);
        wait_done("b2b_second_latency");
        @(negedge clk);

        // reset mid-calculation aborts without done
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort_busy", 32'(busy), 0);
        check_eq("abort_done", 32'(done), 0);
        check_eq("abort_quotient", 32'(quotient), 0);
        check_eq("abort_remainder", 32'(remainder), 0);
        for (int i = 0; i < N + 3; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 0);
        end

        // random operands, including divisor 0
        for (int i = 0; i < 24; i++) begin
            logic [N-1:0] ra, rb;
            ra = N'($urandom_range(0, (1 << N) - 1));
            rb = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
            run_op(ra, rb);
        end

        repeat (3) @(negedge clk);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
